// File: rtl/parity_tx_ctrl.sv
// Byte-in, serial frame-out transmitter: start, 8 data LSB-first, parity, stop.
// Define ODD_PARITY_EN to send odd parity instead of even parity.
`timescale 1ns/1ps

module parity (
  input  logic [7:0] data,
  output logic       par
);
  assign par = ^data;
endmodule

module parity_tx_ctrl #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       par_out
);
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data_q;
  logic          par_raw;
  logic          par_sel;
  logic          wrap;

  parity u_par (
    .data (in_data),
    .par  (par_raw)
  );

`ifdef ODD_PARITY_EN
  assign par_sel = ~par_raw;
`else
  assign par_sel = par_raw;
`endif

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
      tx       <= 1'b1;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      par_out  <= 1'b0;
    end else begin
      // every non-idle state holds its bit for CLKS_PER_BIT cycles
      if (state != IDLE)
        cnt <= wrap ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= START;
            cnt      <= '0;
            bit_idx  <= '0;
            data_q   <= in_data;
            par_out  <= par_sel;
            tx       <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            state <= DATA;
            tx    <= data_q[0];
          end
        end
        DATA: begin
          if (wrap) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= PARITY;
              tx    <= par_out;
            end else begin
              tx <= data_q[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (wrap) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (wrap) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parity_tx_ctrl.sv
// Scoreboard bench for parity_tx_ctrl: random bytes, frame decode on tx.
// A second instance with CLKS_PER_BIT=1 covers the single-cycle-bit case.
`timescale 1ns/1ps

module tb_parity_tx_ctrl;
  localparam int C  = 4;
  localparam int FL = 11 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx, busy, par_out;

  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       r1, tx1, b1, p1;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  parity_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .par_out  (par_out)
  );

  parity_tx_ctrl #(.CLKS_PER_BIT(1)) u1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (v1),
    .in_data  (d1),
    .in_ready (r1),
    .tx       (tx1),
    .busy     (b1),
    .par_out  (p1)
  );

  function automatic logic par_of(input logic [7:0] d);
    int n;
    n = $countones(d);
`ifdef ODD_PARITY_EN
    return (n % 2) == 0;
`else
    return (n % 2) == 1;
`endif
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = par_of(d);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit keep,
                      output time t);
    int n;
    n = 0;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: byte %h never accepted", b);
        in_valid = 1'b0;
        return;
      end
    end
    sb.push_back(b);
    @(posedge clk);
    t = $time;
    #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  initial begin : monitor
    logic [10:0] obs;
    logic        held, coh, ab;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        b = 8'h00;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: start bit with empty queue");
        end else begin
          b = sb.pop_front();
        end
        obs  = '0;
        held = 1'b1;
        coh  = 1'b1;
        ab   = 1'b0;
        check("par_out", 32'(par_out), 32'(par_of(b)));
        for (int k = 0; k < FL; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            ab = 1'b1;
            break;
          end
          if (k % C == 0) obs[k/C] = tx;
          else if (tx !== obs[k/C]) held = 1'b0;
          if (busy !== ~in_ready || in_ready !== 1'b0) coh = 1'b0;
        end
        if (!ab) begin
          check("frame", 32'(obs), 32'(frame_of(b)));
          check("bit_hold", 32'(held), 32'd1);
          check("busy_during_frame", 32'(coh), 32'd1);
          @(negedge clk);
          if (rst_n)
            check("ready_after_frame",
                  32'({in_ready, tx, busy}), 32'b110);
        end
      end
    end
  end

  initial begin : main
    time t0, t1;
    logic [10:0] f1;
    logic [7:0]  rb;
    bit          keep;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_state",
          32'({tx, in_ready, busy, par_out}), 32'b1100);
    check("reset_state_c1",
          32'({tx1, r1, b1, p1}), 32'b1100);

    send(8'hA5, 1'b0, t0);
    send(8'h07, 1'b0, t0);

    send(8'h11, 1'b1, t0);
    send(8'h22, 1'b0, t1);
    check("b2b_period", 32'((t1 - t0) / 10), 32'(FL + 1));

    for (int i = 0; i < 20; i++) begin
      rb   = 8'($urandom);
      keep = 1'($urandom_range(0, 1));
      send(rb, keep, t0);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    send(8'hFF, 1'b0, t0);
    repeat (4 * C) @(posedge clk);
    #3;
    check("mid_frame_busy", 32'({in_ready, busy}), 32'b01);
    rst_n = 1'b0;
    #1;
    check("async_reset",
          32'({tx, in_ready, busy, par_out}), 32'b1100);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("no_xfer_in_reset", 32'({tx, in_ready}), 32'b11);
    rst_n = 1'b1;
    send(8'h00, 1'b0, t0);
    repeat (FL + 4) @(negedge clk);
    check("queue_drained", 32'(sb.size()), 32'd0);

    @(negedge clk);
    v1 = 1'b1;
    d1 = 8'h80;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    f1 = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      f1[k] = tx1;
      if (k == 10) check("c1_ready_low", 32'(r1), 32'd0);
    end
    @(negedge clk);
    check("c1_ready_after", 32'({r1, tx1}), 32'b11);
    check("c1_frame", 32'(f1), 32'(frame_of(8'h80)));
    check("c1_par_out", 32'(p1), 32'(par_of(8'h80)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
